// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetcher with a DEPTH-entry {word, pc} queue.
// Ports: clk, reset (async active-low), imem_rd/imem_addr/imem_data memory
// side, ir/ir_pc/ir_valid/ir_ready decode side, redirect/redirect_pc, halt.
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic          rd_q, rd_d;
  logic [15:0]   addr_q, addr_d;
  logic          resp_q, resp_d;
  logic [15:0]   resp_pc_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [15:0]   ir_q, ir_d;
  logic [15:0]   ir_pc_q, ir_pc_d;
  logic [15:0]   word_q [DEPTH];
  logic [15:0]   pcs_q  [DEPTH];

  logic [CW:0]   occ;
  logic          issue;
  logic          push;
  logic          pop;
  logic          bypass;

  assign imem_rd   = rd_q;
  assign imem_addr = addr_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = (count_q != '0);

  always_comb begin
    // occupancy counts the request on the bus and the response in flight
    occ = (CW+1)'(count_q) + (CW+1)'(rd_q) + (CW+1)'(resp_q);
    issue = !halt && !redirect && (occ < (CW+1)'(DEPTH));
    push  = resp_q && !redirect;
    pop   = ir_valid && ir_ready && !redirect;

    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    rd_d       = issue;
    resp_d     = rd_q && !redirect;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 16'd1;
      addr_d     = fetch_pc_q;
    end

    unique case (1'b1)
      redirect:      count_d = '0;
      push && !pop:  count_d = count_q + CW'(1);
      pop && !push:  count_d = count_q - CW'(1);
      default:       count_d = count_q;
    endcase

    // new head is the incoming word when the queue drains to it
    bypass = push && (count_q == CW'(pop));
    if (count_d != '0) begin
      if (bypass) begin
        ir_d    = imem_data;
        ir_pc_d = resp_pc_q;
      end else begin
        ir_d    = word_q[rd_ptr_d];
        ir_pc_d = pcs_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      resp_q     <= 1'b0;
      resp_pc_q  <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      resp_q     <= resp_d;
      resp_pc_q  <= addr_q;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_ptr_q] <= imem_data;
      pcs_q[wr_ptr_q]  <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit.
// Two instances: RESET_PC=0 (main) and RESET_PC=FFFE (wrap stream).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  logic        rd, valid, ready, halt, redir;
  logic [15:0] addr, data, ir, irpc, rpc;
  logic        rd_b, valid_b;
  logic [15:0] addr_b, data_b, ir_b, irpc_b;

  int checks = 0;
  int failures = 0;
  int pops = 0;

  logic [15:0] exp_q[$];
  logic [15:0] nxt;
  logic [15:0] e;
  logic [15:0] nb;
  logic [15:0] prev_pc = '0;
  logic        prev_rst = 1'b0;

  fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .imem_rd(rd), .imem_addr(addr), .imem_data(data),
    .ir(ir), .ir_pc(irpc), .ir_valid(valid), .ir_ready(ready),
    .redirect(redir), .redirect_pc(rpc), .halt(halt)
  );

  fetch_unit #(.DEPTH(4), .RESET_PC(16'hFFFE)) dut_b (
    .clk(clk), .reset(reset),
    .imem_rd(rd_b), .imem_addr(addr_b), .imem_data(data_b),
    .ir(ir_b), .ir_pc(irpc_b), .ir_valid(valid_b), .ir_ready(1'b1),
    .redirect(1'b0), .redirect_pc(16'h0000), .halt(1'b0)
  );

  // memories: word = A000+addr one cycle after the request, junk otherwise
  always @(posedge clk) begin
    data   <= rd   ? 16'hA000 + addr   : 16'($urandom);
    data_b <= rd_b ? 16'hA000 + addr_b : 16'($urandom);
  end

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // reference: decode sees a sequential stream from the last start point
  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(nxt);
      nxt = nxt + 16'd1;
    end
  endtask

  task automatic model_start(input logic [15:0] pc);
    exp_q.delete();
    nxt = pc;
    refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    refill();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    redir = 1'b0;
    #1;
    chk("rst_rd", 16'(rd), 16'h0);
    chk("rst_addr", addr, 16'h0);
    chk("rst_ir", ir, 16'h0);
    chk("rst_irpc", irpc, 16'h0);
    chk("rst_valid", 16'(valid), 16'h0);
    model_start(16'h0000);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redir = 1'b1;
    rpc   = pc;
    model_start(pc);
  endtask

  // monitor: every accepted head is compared with the model stream
  always @(negedge clk) begin
    if (reset && valid && ready && !redir) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got %h expected none", irpc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", irpc, e);
        chk("pop_ir", ir, 16'hA000 + e);
        pops++;
      end
    end
    if (reset && prev_rst && !valid)
      chk("hold_pc", irpc, prev_pc);
    prev_pc  = irpc;
    prev_rst = reset;
  end

  // wrap instance always accepts, so every valid cycle is one instruction
  always @(negedge clk) begin
    if (!reset) nb = 16'hFFFE;
    else if (valid_b) begin
      chk("wrap_pc", irpc_b, nb);
      chk("wrap_ir", ir_b, 16'hA000 + nb);
      nb = nb + 16'd1;
    end
  end

  initial begin
    int n;
    halt  = 1'b0;
    ready = 1'b1;
    redir = 1'b0;
    rpc   = '0;

    // reset release, streaming
    apply_reset();
    tick();
    chk("s_rd0", 16'(rd), 16'h1);
    chk("s_addr0", addr, 16'h0);
    chk("s_valid0", 16'(valid), 16'h0);
    tick();
    chk("s_addr1", addr, 16'h1);
    chk("s_valid1", 16'(valid), 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s_valid", 16'(valid), 16'h1);
      chk("s_pc", irpc, 16'(i));
    end

    // decode stalled: credit limits requests
    ready = 1'b0;
    apply_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n += int'(rd);
    end
    chk("fill_reqs", 16'(n), 16'd4);
    chk("fill_rd", 16'(rd), 16'h0);
    chk("fill_head", irpc, 16'h0);
    ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      tick();
      chk("drain_valid", 16'(valid), 16'h1);
      chk("drain_pc", irpc, 16'(i));
      if (i == 2) chk("resume_addr", addr, 16'h4);
    end

    // redirect with 3 queued and one response in flight
    ready = 1'b0;
    apply_reset();
    repeat (5) tick();
    chk("r_pre_valid", 16'(valid), 16'h1);
    do_redirect(16'h0040);
    tick();
    redir = 1'b0;
    chk("r_valid1", 16'(valid), 16'h0);
    chk("r_rd1", 16'(rd), 16'h0);
    chk("r_hold", irpc, 16'h0);
    tick();
    chk("r_rd2", 16'(rd), 16'h1);
    chk("r_addr2", addr, 16'h0040);
    tick();
    chk("r_valid3", 16'(valid), 16'h0);
    tick();
    chk("r_valid4", 16'(valid), 16'h1);
    chk("r_pc4", irpc, 16'h0040);
    ready = 1'b1;
    repeat (4) tick();

    // halt with one request in flight
    apply_reset();
    tick();
    chk("h_addr", addr, 16'h0);
    halt = 1'b1;
    tick();
    chk("h_rd1", 16'(rd), 16'h0);
    tick();
    chk("h_valid", 16'(valid), 16'h1);
    chk("h_pc", irpc, 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h_rd_idle", 16'(rd), 16'h0);
    end
    halt = 1'b0;
    tick();
    chk("h_rd_resume", 16'(rd), 16'h1);
    chk("h_addr_resume", addr, 16'h1);
    repeat (4) tick();

    // reset mid-operation
    ready = 1'b0;
    apply_reset();
    repeat (4) tick();
    #2;
    ready = 1'b1;
    apply_reset();
    tick();
    tick();
    tick();
    chk("x_valid", 16'(valid), 16'h1);
    chk("x_pc", irpc, 16'h0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) apply_reset();
      ready = ($urandom_range(0, 9) < 7);
      halt  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 1)
          do_redirect(16'hFFFC + 16'($urandom_range(0, 3)));
        else
          do_redirect(16'($urandom));
      end else begin
        redir = 1'b0;
      end
      tick();
    end
    redir = 1'b0;
    ready = 1'b0;

    checks++;
    if (pops < 200) begin
      failures++;
      $display("FAIL progress: got %0d pops expected >= 200", pops);
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
